// File: rtl/switch_button_reader.sv
// Slide-switch / push-button input port: two-flop synchronizer, per-bit debounce,
// latched button-press flags, and a registered read port with a pending-press interrupt.
module switch_button_reader #(
    parameter int DEBOUNCE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sw,
    input  logic [3:0]  btn,
    input  logic        re,
    input  logic        sel,
    output logic [15:0] out,
    output logic        valid,
    output logic        irq
);

    localparam int               NB      = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    // Bits [7:0] are the switches, bits [11:8] the buttons, matching the level read layout.
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    stable_d;
    logic [CNT_W-1:0] cnt   [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [3:0]       flags;
    logic [3:0]       flags_d;
    logic [3:0]       press;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
        stable_d = stable;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_d[i] = sync2[i];
                end else begin
                    cnt_d[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        press = stable_d[11:8] & ~stable[11:8];
        // A press landing on the same edge as a read-clear survives the clear.
        flags_d = ((re && sel) ? 4'b0000 : flags) | press;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            // NOTE: the counter array is small and must restart from zero, so it is reset like plain flops.
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
            flags  <= '0;
            out    <= '0;
            valid  <= 1'b0;
        end else begin
            sync1  <= {btn, sw};
            sync2  <= sync1;
            stable <= stable_d;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= cnt_d[i];
            end
            flags  <= flags_d;
            valid  <= re;
            if (re) begin
                out <= sel ? {12'b0, flags} : {4'b0, stable};
            end
        end
    end

    assign irq = |flags;

endmodule

// File: tb/tb_switch_button_reader.sv
// Self-checking bench for switch_button_reader: directed scenarios plus a randomized
// phase, all compared against an edge-by-edge behavioural model of the port.
module tb_switch_button_reader;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic        re;
    logic        sel;
    logic [15:0] out;
    logic        valid;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: raw history, per-bit run lengths of disagreement.
    logic [11:0] hist [$];
    int          run  [12];
    logic [11:0] m_stable;
    logic [3:0]  m_flags;
    logic [15:0] m_out;
    logic        m_valid;

    switch_button_reader #(.DEBOUNCE(DEB), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .btn   (btn),
        .re    (re),
        .sel   (sel),
        .out   (out),
        .valid (valid),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int b = 0; b < 12; b++) run[b] = 0;
        m_stable = '0;
        m_flags  = '0;
        m_out    = '0;
        m_valid  = 1'b0;
    endtask

    // One rising edge: synced value is the raw input seen two edges earlier; a bit's
    // debounced level follows it once it has disagreed for DEB consecutive edges.
    task automatic model_step();
        logic [11:0] synced;
        logic [11:0] ev;
        synced = (hist.size() == 2) ? hist[0] : 12'h000;
        hist.push_back({btn, sw});
        if (hist.size() > 2) void'(hist.pop_front());
        if (re) m_out = sel ? {12'h000, m_flags} : {4'h0, m_stable};
        m_valid = re;
        ev = '0;
        for (int b = 0; b < 12; b++) begin
            if (synced[b] != m_stable[b]) begin
                run[b]++;
                if (run[b] == DEB) begin
                    m_stable[b] = synced[b];
                    run[b] = 0;
                    ev[b] = 1'b1;
                end
            end else begin
                run[b] = 0;
            end
        end
        if (re && sel) m_flags = '0;
        m_flags |= ev[11:8] & m_stable[11:8];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_out", out, m_out);
        check("model_valid", 16'(valid), 16'(m_valid));
        check("model_irq", 16'(irq), 16'(|m_flags));
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b0;
        sw = '0; btn = '0; re = 1'b0; sel = 1'b0;
        model_reset();
        #2;
        check("reset_out", out, 16'h0000);
        check("reset_valid", 16'(valid), 16'h0);
        check("reset_irq", 16'(irq), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        ticks(2);

        // Switch level: a read on the 6th edge still sees the old level, the 7th sees A5.
        sw = 8'hA5;
        ticks(5);
        re = 1'b1; sel = 1'b0;
        tick();
        check("sw_early", out, 16'h0000);
        check("sw_early_valid", 16'(valid), 16'h1);
        tick();
        check("sw_level", out, 16'h00A5);
        check("sw_b2b_valid", 16'(valid), 16'h1);
        re = 1'b0;
        tick();
        check("sw_hold", out, 16'h00A5);
        check("sw_valid_drop", 16'(valid), 16'h0);

        // Bounce on btn[0]: 2-cycle pulses never debounce, then a steady press does.
        for (int t = 0; t < 10; t++) begin
            btn[0] = ~btn[0];
            ticks(2);
            check("bounce_irq", 16'(irq), 16'h0);
        end
        btn[0] = 1'b1;
        ticks(5);
        check("bounce_pre", 16'(irq), 16'h0);
        tick();
        check("bounce_irq_set", 16'(irq), 16'h1);

        // Read-clear, then a second read of the now-empty flags.
        re = 1'b1; sel = 1'b1;
        tick();
        check("rc_out", out, 16'h0001);
        check("rc_irq", 16'(irq), 16'h0);
        tick();
        check("rc_second", out, 16'h0000);
        re = 1'b0;

        // Collision: btn[2] press lands on the edge of a read-clear of flag bit 0.
        btn[0] = 1'b0;
        ticks(6);
        check("release0_irq", 16'(irq), 16'h0);
        btn[0] = 1'b1;
        ticks(6);
        check("repress0_irq", 16'(irq), 16'h1);
        btn[2] = 1'b1;
        ticks(5);
        re = 1'b1; sel = 1'b1;
        tick();
        check("coll_out", out, 16'h0001);
        check("coll_irq", 16'(irq), 16'h1);
        tick();
        check("coll_flags", out, 16'h0004);
        check("coll_cleared", 16'(irq), 16'h0);
        re = 1'b0;

        // Release of btn[1] never raises a flag; its level bit drops.
        btn[1] = 1'b1;
        ticks(6);
        check("press1_irq", 16'(irq), 16'h1);
        re = 1'b1; sel = 1'b0;
        tick();
        check("press1_level", out, 16'h07A5);
        re = 1'b0;
        btn[1] = 1'b0;
        ticks(6);
        re = 1'b1;
        tick();
        check("rel_bit9", 16'(out[9]), 16'h0);
        check("rel_level", out, 16'h05A5);

        // Reset mid-debounce of btn[3] and mid-read, no clock edge involved.
        btn[3] = 1'b1;
        ticks(3);
        check("pre_rst_irq", 16'(irq), 16'h1);
        reset = 1'b0;
        re = 1'b0;
        #1;
        check("rst_out", out, 16'h0000);
        check("rst_valid", 16'(valid), 16'h0);
        check("rst_irq", 16'(irq), 16'h0);
        model_reset();
        #1;
        reset = 1'b1;
        ticks(5);
        check("post_rst_pre", 16'(irq), 16'h0);
        tick();
        check("post_rst_irq", 16'(irq), 16'h1);
        re = 1'b1; sel = 1'b1;
        tick();
        check("post_rst_flags", out, 16'h000D);
        re = 1'b0;
        tick();

        // Randomized phase against the model, with one asynchronous reset in the middle.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) begin
                int b;
                b = $urandom_range(11);
                if (b < 8) sw[b] = ~sw[b];
                else btn[b-8] = ~btn[b-8];
            end
            re  = ($urandom_range(2) == 0);
            sel = $urandom_range(1) == 1;
            if (c == 400) begin
                #2;
                reset = 1'b0;
                #1;
                check("rand_rst_out", out, 16'h0000);
                model_reset();
                reset = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_button_reader.md
# switch_button_reader

Input-side counterpart to the LED output register: samples the board's slide switches and push-buttons, synchronizes and debounces them, latches button-press events, and returns them to the processor through a read-enable bus port. It sits on the same 16-bit I/O data path as the LED output register. An interrupt line is asserted while any press event is pending.

## Interface
- DEBOUNCE, 50000: consecutive clock cycles a synchronized input must differ from its debounced value before that value is updated; minimum 2.
- CNT_W, 16: debounce counter width; must hold DEBOUNCE-1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset); clears all state immediately, independent of clk.
- sw  in  8  raw slide switches, asynchronous to clk.
- btn  in  4  raw push-buttons, asynchronous to clk, 1 = pressed.
- re  in  1  read enable, sampled on clk edge.
- sel  in  1  read select: 0 = levels, 1 = press-event flags (read-to-clear).
- out  out  16  registered read data.
- valid  out  1  one-cycle pulse marking out as freshly loaded.
- irq  out  1  high while any press flag is set.

## Operation
- Synchronizer: two flops per input bit (12 bits), reset value 0.
- Debounce, per bit, with debounced value `stable` (reset 0) and counter `cnt` (reset 0):
  - synced == stable: cnt <= 0.
  - synced != stable and cnt < DEBOUNCE-1: cnt <= cnt+1.
  - synced != stable and cnt == DEBOUNCE-1: stable <= synced, cnt <= 0.
  - A glitch shorter than DEBOUNCE cycles never changes stable; any return to equality restarts the count.
- Press flags `flags[3:0]` (reset 0): bit i is set on the edge where stable btn[i] updates 0→1. Release (1→0) never sets a flag.
- Read on edge with re=1:
  - sel=0: out <= {4'b0, stable_btn[3:0], stable_sw[7:0]}; flags unchanged.
  - sel=1: out <= {12'b0, flags}; flags cleared at the same edge.
  - Simultaneous set and read-clear of the same bit: the set wins. out shows the pre-edge value (bit 0), and the flag is 1 afterwards.
- With re=0: out holds its last value and flags are untouched.
- irq = |flags. It is driven from registered state only, with no combinational path from inputs.
- Reset values: out=16'h0000, valid=0, irq=0. All sync flops, stable values, counters, and flags are 0.
- Reset asserted mid-debounce or mid-read: everything is cleared immediately. After release, the block restarts from the reset state. Inputs already held high re-debounce from zero. A button held through reset release produces one fresh press flag.

## Timing
- Raw change to synced: 2 edges.
- Synced change to stable update: DEBOUNCE edges. Raw change to stable is therefore 2+DEBOUNCE edges when the input is steady.
- A flag sets and irq rises on the same edge stable_btn rises.
- Read latency: out and valid update on the edge where re=1 is sampled. valid is high for exactly one cycle per sampled re. Back-to-back re gives a valid pulse on every cycle.
- After a sel=1 read-clear edge, irq is 0 in the following cycle unless a set occurred at that edge.

## Test plan
(DEBOUNCE=4)
- Reset: pulse reset low mid-debounce with btn held and no clock edge → out=0x0000, valid=0, irq=0 immediately. After release, with btn still held, flag bit sets after 6 edges.
- Switch level: sw=8'hA5 held 6+ edges, then re=1, sel=0 → out=16'h00A5 and valid=1 for one cycle. A read after only 5 edges returns 16'h0000.
- Bounce: btn[0] toggles every 2 cycles for 20 cycles, then holds 1 → no flag during toggling. Exactly one flag, bit 0, after 4 steady synced cycles. irq=1.
- Read-clear: re=1, sel=1 with flags=4'b0001 → out=16'h0001, then flags=0 and irq=0 the next cycle. A second sel=1 read returns 16'h0000.
- Collision: btn[2] stable update coincides with a sel=1 read while flags=4'b0001 → out=16'h0001, then flags=4'b0100 and irq stays 1.
- Release: btn[1] goes 1→0 and is held → no flag set. A sel=0 read shows bit 9 = 0 after 6 edges.
